// File: rtl/key_scan.sv
// key_scan: 4x4 keypad scanner with frame-based debounce.
//
// One column is strobed low at a time; each column slot lasts 2^(N-2) clk
// cycles. The synchronized rows are sampled once at the end of each slot.
// The four samples of a frame are folded into a hit count and a key code.
// A debounce FSM runs once per frame end and accepts a press or a release
// after DB_FRAMES consecutive agreeing frames. Frames with two or more keys
// are treated like frames with no key, so no ghost key is reported.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   row[3:0]     keypad row returns, active-low, asynchronous to clk
//   col[3:0]     column strobes, active-low, exactly one bit low
//   key_code     last accepted key, {col_idx[1:0], row_idx[1:0]}
//   key_valid    one-clk pulse when a press is accepted
//   key_release  one-clk pulse when a release is accepted
//   key_down     high while the accepted key is held
module key_scan #(
  parameter int N         = 18,
  parameter int DB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_release,
  output logic       key_down
);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  localparam logic [4:0] DB = 5'(DB_FRAMES);

  // Row synchronizer; resets to "no key pressed".
  logic [3:0] row_meta;
  logic [3:0] rows_s;

  // Scan counter.
  logic [N-1:0] q;
  logic [N-1:0] q_nxt;
  logic [1:0]   col_idx;
  logic [1:0]   col_idx_nxt;
  logic         sample;
  logic         frame_end;

  // Frame accumulator.
  logic [1:0] hits;
  logic [3:0] last_code;
  logic [2:0] slot_pop;
  logic [1:0] slot_row;
  logic [3:0] raw_sum;
  logic [1:0] hits_sum;
  logic [3:0] code_sum;
  logic       frame_single;

  // Debounce FSM.
  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] cand, cand_nxt;
  logic [4:0] cnt_inc;
  logic [3:0] key_code_nxt;
  logic       key_down_nxt;
  logic       key_valid_nxt;
  logic       key_release_nxt;

  assign q_nxt       = q + N'(1);
  assign col_idx     = q[N-1:N-2];
  assign col_idx_nxt = q_nxt[N-1:N-2];
  assign sample      = &q[N-3:0];
  assign frame_end   = sample && (col_idx == 2'd3);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      rows_s   <= 4'b1111;
      q        <= '0;
      col      <= 4'b1110;
    end else begin
      row_meta <= row;
      rows_s   <= row_meta;
      q        <= q_nxt;
      // Decoded from the next count so col always matches the current slot.
      col      <= ~(4'b0001 << col_idx_nxt);
    end
  end

  // Fold this slot's sample into the running frame totals.
  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    slot_pop = '0;
    slot_row = '0;
    for (int r = 3; r >= 0; r--) begin
      if (!rows_s[r]) begin
        slot_pop = slot_pop + 3'd1;
        slot_row = 2'(r);
      end
    end
    raw_sum  = {2'b00, hits} + {1'b0, slot_pop};
    hits_sum = (raw_sum >= 4'd2) ? 2'd2 : raw_sum[1:0];
    code_sum = (slot_pop != 3'd0) ? {col_idx, slot_row} : last_code;
  end

  // The slot-3 sample belongs to the frame it closes, so classification uses
  // the folded totals rather than the stored ones.
  assign frame_single = frame_end && (hits_sum == 2'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits      <= '0;
      last_code <= '0;
    end else if (sample) begin
      if (frame_end) begin
        hits      <= '0;
        last_code <= '0;
      end else begin
        hits      <= hits_sum;
        last_code <= code_sum;
      end
    end
  end

  assign cnt_inc = {1'b0, cnt} + 5'd1;

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cand_nxt        = cand;
    key_code_nxt    = key_code;
    key_down_nxt    = key_down;
    key_valid_nxt   = 1'b0;
    key_release_nxt = 1'b0;
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (frame_single) begin
            cand_nxt = code_sum;
            cnt_nxt  = 4'd1;
            if (DB_FRAMES == 1) begin
              state_nxt     = PRESSED;
              key_code_nxt  = code_sum;
              key_down_nxt  = 1'b1;
              key_valid_nxt = 1'b1;
            end else begin
              state_nxt = CAND;
            end
          end
        end
        CAND: begin
          if (frame_single && (code_sum == cand)) begin
            cnt_nxt = cnt_inc[3:0];
            if (cnt_inc == DB) begin
              state_nxt     = PRESSED;
              key_code_nxt  = cand;
              key_down_nxt  = 1'b1;
              key_valid_nxt = 1'b1;
            end
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = 4'd0;
          end
        end
        PRESSED: begin
          if (!(frame_single && (code_sum == key_code))) begin
            cnt_nxt = 4'd1;
            if (DB_FRAMES == 1) begin
              state_nxt       = IDLE;
              cnt_nxt         = 4'd0;
              key_down_nxt    = 1'b0;
              key_release_nxt = 1'b1;
            end else begin
              state_nxt = REL;
            end
          end
        end
        REL: begin
          if (frame_single && (code_sum == key_code)) begin
            // A single missing frame is a glitch, not a release.
            state_nxt = PRESSED;
          end else if (cnt_inc == DB) begin
            state_nxt       = IDLE;
            cnt_nxt         = 4'd0;
            key_down_nxt    = 1'b0;
            key_release_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt_inc[3:0];
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      cand        <= '0;
      key_code    <= '0;
      key_down    <= 1'b0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cand        <= cand_nxt;
      key_code    <= key_code_nxt;
      key_down    <= key_down_nxt;
      key_valid   <= key_valid_nxt;
      key_release <= key_release_nxt;
    end
  end

endmodule
